// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: holds the PC, fetches one word at a time from a
// variable-latency instruction memory (single outstanding request) and
// presents it to IF/ID, inserting NOP bubbles and flushing on redirects.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset_n,
    output logic        IMem_Req,
    output logic [31:0] IMem_Addr,
    input  logic        IMem_Rvalid,
    input  logic [31:0] IMem_Rdata,
    input  logic        IF_ID_pipeline_stall,
    input  logic        Branch_Taken,
    input  logic [31:0] Branch_Target,
    output logic [31:0] Instruction_IF,
    output logic [31:0] PC_Plus_4_IF,
    output logic        Fetch_Valid
);

    typedef enum logic [2:0] {
        S_RST,
        S_REQ,
        S_WAIT,
        S_DRAIN,
        S_VALID
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] pc_inc;
    logic [31:0] tgt_aligned;

    assign pc_inc       = pc_q + 32'd4;
    assign tgt_aligned  = Branch_Target & ~32'h3;
    assign PC_Plus_4_IF = pc_inc;

    // State, PC and instruction buffer registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_RST;
            pc_q    <= RESET_PC;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
        end
    end

    // Next-state and output decode; a redirect wins in every state but S_RST
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        buf_d          = buf_q;
        IMem_Req       = 1'b0;
        IMem_Addr      = pc_q & ~32'h3;
        Instruction_IF = '0;
        Fetch_Valid    = 1'b0;
        unique case (state_q)
            S_RST: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                if (Branch_Taken) begin
                    pc_d = tgt_aligned;
                end else begin
                    IMem_Req = 1'b1;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (Branch_Taken) begin
                    // A response landing with the redirect is stale; otherwise
                    // it is still in flight and must be drained first.
                    pc_d    = tgt_aligned;
                    state_d = IMem_Rvalid ? S_REQ : S_DRAIN;
                end else if (IMem_Rvalid) begin
                    buf_d   = IMem_Rdata;
                    state_d = S_VALID;
                end
            end
            S_DRAIN: begin
                if (Branch_Taken) pc_d = tgt_aligned;
                if (IMem_Rvalid) state_d = S_REQ;
            end
            S_VALID: begin
                if (Branch_Taken) begin
                    pc_d    = tgt_aligned;
                    state_d = S_REQ;
                end else begin
                    Instruction_IF = buf_q;
                    Fetch_Valid    = 1'b1;
                    if (!IF_ID_pipeline_stall) begin
                        // Consumed: fetch the next sequential word immediately.
                        pc_d      = pc_inc;
                        IMem_Req  = 1'b1;
                        IMem_Addr = pc_inc & ~32'h3;
                        state_d   = S_WAIT;
                    end
                end
            end
            default: state_d = S_RST;
        endcase
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: transaction-level model of the fetch
// stream plus a bench-owned instruction memory with per-request latency.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RPC = 32'h0040_0000;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        IMem_Req;
    logic [31:0] IMem_Addr;
    logic        IMem_Rvalid = 1'b0;
    logic [31:0] IMem_Rdata = '0;
    logic        IF_ID_pipeline_stall = 1'b0;
    logic        Branch_Taken = 1'b0;
    logic [31:0] Branch_Target = '0;
    logic [31:0] Instruction_IF;
    logic [31:0] PC_Plus_4_IF;
    logic        Fetch_Valid;

    instruction_fetch_unit #(.RESET_PC(RPC)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .IMem_Req(IMem_Req), .IMem_Addr(IMem_Addr),
        .IMem_Rvalid(IMem_Rvalid), .IMem_Rdata(IMem_Rdata),
        .IF_ID_pipeline_stall(IF_ID_pipeline_stall),
        .Branch_Taken(Branch_Taken), .Branch_Target(Branch_Target),
        .Instruction_IF(Instruction_IF), .PC_Plus_4_IF(PC_Plus_4_IF),
        .Fetch_Valid(Fetch_Valid)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int failures = 0;

    // Model of the fetch stream
    logic [31:0] pc_m;        // address of instruction presented / being fetched
    bit          rst_cycle;   // first cycle after reset release
    bit          need_req;    // a request is due this cycle
    bit          have;        // an instruction is ready to present
    logic [31:0] have_data;
    bit          pend;        // memory request in flight
    bit          stale;       // in-flight response was superseded by a redirect
    int          cnt;
    logic [31:0] pend_addr;
    int          lat_next = 1;

    // Sampled outputs of the last step, for literal checks
    logic        s_req, s_valid;
    logic [31:0] s_addr, s_instr, s_pp4;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0001;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        pc_m = RPC; rst_cycle = 1; need_req = 0; have = 0; have_data = '0;
        pend = 0; stale = 0; cnt = 0; pend_addr = '0;
    endtask

    task automatic issue(input logic [31:0] a);
        pend = 1; stale = 0; cnt = lat_next; pend_addr = a;
    endtask

    // One clock cycle: called at posedge+1, returns at next posedge+1.
    task automatic step(input bit br, input logic [31:0] tgt, input bit st, input bit frv);
        bit rv, live;
        bit e_req, e_valid;
        logic [31:0] e_addr, e_instr, e_pp4;
        rv = pend && (cnt == 1);
        live = pend && !rv;
        Branch_Taken = br; Branch_Target = tgt; IF_ID_pipeline_stall = st;
        IMem_Rvalid = rv || frv;
        IMem_Rdata = rv ? mem(pend_addr) : $urandom;
        #4;
        e_req = 0; e_valid = 0; e_addr = pc_m; e_instr = '0; e_pp4 = pc_m + 32'd4;
        if (rst_cycle || br) begin
        end else if (have) begin
            e_valid = 1; e_instr = have_data;
            if (!st) begin e_req = 1; e_addr = pc_m + 32'd4; end
        end else if (need_req) begin
            e_req = 1;
        end
        s_req = IMem_Req; s_addr = IMem_Addr; s_valid = Fetch_Valid;
        s_instr = Instruction_IF; s_pp4 = PC_Plus_4_IF;
        chk("req", {31'b0, IMem_Req}, {31'b0, e_req});
        if (e_req) chk("addr", IMem_Addr, e_addr);
        chk("valid", {31'b0, Fetch_Valid}, {31'b0, e_valid});
        chk("instr", Instruction_IF, e_instr);
        chk("pc4", PC_Plus_4_IF, e_pp4);
        // advance the model past this edge
        if (rst_cycle) begin
            rst_cycle = 0; need_req = 1;
        end else if (br) begin
            pc_m = tgt & ~32'h3; have = 0; need_req = 0;
            if (live) stale = 1;
            else begin pend = 0; need_req = 1; end
        end else if (have) begin
            if (!st) begin pc_m = pc_m + 32'd4; have = 0; issue(pc_m); end
        end else if (need_req) begin
            issue(pc_m); need_req = 0;
        end else if (rv) begin
            pend = 0;
            if (stale) need_req = 1;
            else begin have = 1; have_data = mem(pend_addr); end
        end
        if (live && pend) cnt--;
        @(posedge Clk); #1;
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_req"}, {31'b0, IMem_Req}, 32'd0);
        chk({nm, "_valid"}, {31'b0, Fetch_Valid}, 32'd0);
        chk({nm, "_instr"}, Instruction_IF, 32'd0);
        chk({nm, "_pc4"}, PC_Plus_4_IF, RPC + 32'd4);
    endtask

    initial begin
        bit reached;
        model_reset();
        repeat (3) @(posedge Clk);
        #1;
        chk_reset_outputs("rst");
        Reset_n = 1'b1;

        // Reset release, L=1, no stall
        lat_next = 1;
        step(1, 32'h1234_5678, 0, 0);         // S_RST ignores the redirect
        chk("c1_noreq", {31'b0, s_req}, 32'd0);
        step(0, 0, 0, 0);
        chk("c2_req", {31'b0, s_req}, 32'd1);
        chk("c2_addr", s_addr, 32'h0040_0000);
        step(0, 0, 0, 0);
        chk("c3_bubble", s_instr, 32'd0);
        step(0, 0, 0, 0);
        chk("c4_instr", s_instr, mem(32'h0040_0000));
        chk("c4_pc4", s_pp4, 32'h0040_0004);
        chk("c4_next", s_addr, 32'h0040_0004);
        step(0, 0, 0, 0);
        chk("c5_valid", {31'b0, s_valid}, 32'd0);
        // stall while Instr@0x00400004 is presented
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 0);
            chk("stall_pc4", s_pp4, 32'h0040_0008);
            chk("stall_noreq", {31'b0, s_req}, 32'd0);
        end
        lat_next = 4;
        step(0, 0, 0, 0);
        chk("unstall_req", {31'b0, s_req}, 32'd1);
        chk("unstall_addr", s_addr, 32'h0040_0008);
        // redirect during S_WAIT with L=4
        step(1, 32'h0040_0103, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        lat_next = 1;
        step(0, 0, 0, 0);                      // stale Rvalid
        chk("stale_valid", {31'b0, s_valid}, 32'd0);
        step(0, 0, 0, 0);
        chk("redir_addr", s_addr, 32'h0040_0100);
        chk("redir_req", {31'b0, s_req}, 32'd1);
        step(0, 0, 0, 0);
        // redirect in S_VALID under stall
        step(1, 32'h0040_0200, 1, 0);
        chk("brv_valid", {31'b0, s_valid}, 32'd0);
        chk("brv_instr", s_instr, 32'd0);
        step(0, 0, 1, 0);
        chk("brv_req", {31'b0, s_req}, 32'd1);
        chk("brv_addr", s_addr, 32'h0040_0200);
        step(0, 0, 0, 0);
        // PC wrap at the top of the address space
        step(1, 32'hFFFF_FFFC, 0, 0);
        step(0, 0, 0, 0);
        chk("wrap_addr0", s_addr, 32'hFFFF_FFFC);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("wrap_pc4", s_pp4, 32'h0000_0000);
        chk("wrap_next", s_addr, 32'h0000_0000);

        // Random traffic: latency, stalls and redirects
        for (int i = 0; i < 3000; i++) begin
            lat_next = $urandom_range(1, 4);
            step($urandom_range(0, 11) == 0, $urandom, $urandom_range(0, 2) == 0, 0);
        end

        // Asynchronous reset in the middle of S_WAIT
        lat_next = 4;
        step(1, 32'h0000_2000, 0, 0);
        reached = 0;
        for (int i = 0; i < 20 && !reached; i++) begin
            step(0, 0, 0, 0);
            reached = pend && !stale && !have && cnt == 4;
        end
        chk("reach_wait", {31'b0, reached}, 32'd1);
        IMem_Rvalid = 1'b0; Branch_Taken = 1'b0;
        Reset_n = 1'b0;
        #1;
        chk_reset_outputs("arst");
        @(posedge Clk); #1;
        chk_reset_outputs("arst_hold");
        model_reset();
        Reset_n = 1'b1;
        step(0, 0, 0, 1);                      // late Rvalid in S_RST
        step(0, 0, 0, 1);                      // late Rvalid in S_REQ
        chk("arst_req_addr", s_addr, RPC);
        for (int i = 0; i < 500; i++) begin
            lat_next = $urandom_range(1, 3);
            step($urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 3) == 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
